// File: rtl/elastic_pipe_reg.sv
// ---------------------------------------------------------------------------
// elastic_pipe_reg
//
// Valid/ready pipeline register built as a two-entry skid buffer. Messages
// accepted on the enq side come out on the deq side in FIFO order, with one
// cycle of latency. The block sustains one message per cycle.
//
// Both handshake outputs (enq_rdy, deq_val) depend only on the state
// register. This breaks the combinational ready chain between neighbouring
// pipeline stages, and no enq_* input reaches a deq_* output in the same
// cycle.
//
// Parameters:
//   p_nbits      message width in bits
//
// Ports:
//   clk          clock; all state updates on posedge
//   reset        synchronous, active-high; empties the buffer in one cycle
//   enq_val      producer has a valid message
//   enq_rdy      block can accept a message this cycle (registered)
//   enq_msg      incoming message
//   deq_val      block presents a valid message (registered)
//   deq_rdy      consumer accepts this cycle
//   deq_msg      outgoing message, always the oldest held entry
//   stall_count  (only with ELASTIC_PIPE_REG_STALL_CNT_EN) saturating count
//                of cycles with enq_val high while enq_rdy is low
//
// Build option:
//   `define ELASTIC_PIPE_REG_STALL_CNT_EN adds the stall_count port and its
//   counter. Without the macro the port and the counter are absent, and the
//   rest of the behaviour is unchanged.
// ---------------------------------------------------------------------------
module elastic_pipe_reg #(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_nbits-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg
`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // main_reg is the head of the queue and always drives deq_msg.
    // skid_reg holds the second entry only while the state is TWO.
    logic [p_nbits-1:0] main_reg;
    logic [p_nbits-1:0] skid_reg;

    logic enq_fire;
    logic deq_fire;
    logic load_main_enq;
    logic load_main_skid;
    logic load_skid;

    assign enq_rdy  = (state != TWO);
    assign deq_val  = (state != EMPTY);
    assign deq_msg  = main_reg;

    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;

    // State register: the only reset flop in the datapath control.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and data-register load enables.
    always_comb begin
        state_next     = state;
        load_main_enq  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        case (state)
            EMPTY: begin
                if (enq_fire) begin
                    load_main_enq = 1'b1;
                    state_next    = ONE;
                end
            end
            ONE: begin
                if (enq_fire && deq_fire) begin
                    // Pass-through: the head leaves while the new message
                    // takes its place, so throughput stays at one per cycle.
                    load_main_enq = 1'b1;
                    state_next    = ONE;
                end else if (enq_fire) begin
                    load_skid  = 1'b1;
                    state_next = TWO;
                end else if (deq_fire) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // enq cannot fire here because enq_rdy is low.
                if (deq_fire) begin
                    load_main_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: begin
                // Unused encoding recovers to a clean, empty buffer.
                state_next = EMPTY;
            end
        endcase
    end

    // Message storage is not reset; deq_msg is don't-care while deq_val is low.
    always_ff @(posedge clk) begin
        if (load_main_enq) begin
            main_reg <= enq_msg;
        end else if (load_main_skid) begin
            main_reg <= skid_reg;
        end
        if (load_skid) begin
            skid_reg <= enq_msg;
        end
    end

`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
    // Counts producer stalls, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 32'd0;
        end else if (enq_val && !enq_rdy && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_elastic_pipe_reg
//
// Self-checking bench for elastic_pipe_reg. The reference model is a plain
// two-deep FIFO held in a SystemVerilog queue:
//   - ready = fewer than two entries held
//   - valid = at least one entry held
//   - the head of the queue is the expected deq_msg
// Inputs are driven 1 time unit after posedge. Outputs are compared at the
// same point, which is away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_elastic_pipe_reg;

    localparam int NB = 8;

    logic          clk;
    logic          reset;
    logic          enq_val;
    logic          enq_rdy;
    logic [NB-1:0] enq_msg;
    logic          deq_val;
    logic          deq_rdy;
    logic [NB-1:0] deq_msg;
`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
    logic [31:0]   stall_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [NB-1:0] mq[$];
    int            n_enq = 0;
    int            n_deq = 0;
    logic [31:0]   m_stall = 0;

    elastic_pipe_reg #(.p_nbits(NB)) dut (
        .clk     (clk),
        .reset   (reset),
        .enq_val (enq_val),
        .enq_rdy (enq_rdy),
        .enq_msg (enq_msg),
        .deq_val (deq_val),
        .deq_rdy (deq_rdy),
        .deq_msg (deq_msg)
`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advances one clock and applies the FIFO rules to the model.
    // Fires are decided from the pre-edge occupancy and inputs.
    task automatic tick();
        bit            ef;
        bit            df;
        bit            st;
        logic [NB-1:0] m;
        df = (reset == 1'b0) && (mq.size() > 0) && (deq_rdy == 1'b1);
        ef = (reset == 1'b0) && (enq_val == 1'b1) && (mq.size() < 2);
        st = (enq_val == 1'b1) && (mq.size() >= 2);
        m  = enq_msg;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_stall = 0;
        end else begin
            if (df) begin
                void'(mq.pop_front());
                n_deq++;
            end
            if (ef) begin
                mq.push_back(m);
                n_enq++;
            end
            if (st && m_stall != 32'hFFFF_FFFF) m_stall++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enq_val = 1'b0; deq_rdy = 1'b1; enq_msg = '0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (enq_rdy !== 1'b1) begin
                errors++; $display("FAIL reset_enq_rdy cyc %0d got %b exp 1", i, enq_rdy);
            end
            checks++;
            if (deq_val !== 1'b0) begin
                errors++; $display("FAIL reset_deq_val cyc %0d got %b exp 0", i, deq_val);
            end
            tick();
        end
    endtask

    task automatic test_single();
        deq_rdy = 1'b1; enq_val = 1'b1; enq_msg = 8'hA5;
        tick();
        enq_val = 1'b0; enq_msg = 8'h00;
        checks++;
        if (deq_val !== 1'b1) begin
            errors++; $display("FAIL single_deq_val got %b exp 1", deq_val);
        end
        checks++;
        if (deq_msg !== 8'hA5) begin
            errors++; $display("FAIL single_deq_msg got %h exp a5", deq_msg);
        end
        tick();
        checks++;
        if (deq_val !== 1'b0) begin
            errors++; $display("FAIL single_drain got %b exp 0", deq_val);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = n_deq;
        deq_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            enq_val = 1'b1; enq_msg = NB'(i);
            checks++;
            if (enq_rdy !== 1'b1) begin
                errors++; $display("FAIL stream_enq_rdy msg %0d got %b exp 1", i, enq_rdy);
            end
            tick();
            checks++;
            if (deq_val !== 1'b1 || deq_msg !== NB'(i)) begin
                errors++; $display("FAIL stream_out msg %0d got val %b msg %h exp val 1 msg %h",
                                   i, deq_val, deq_msg, NB'(i));
            end
        end
        enq_val = 1'b0;
        tick();
        checks++;
        if ((n_deq - d0) != 16 || deq_val !== 1'b0) begin
            errors++; $display("FAIL stream_count got %0d deqs val %b exp 16 val 0", n_deq - d0, deq_val);
        end
    endtask

    task automatic test_backpressure();
        deq_rdy = 1'b0;
        enq_val = 1'b1; enq_msg = 8'h11; tick();
        enq_msg = 8'h22;
        checks++;
        if (enq_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_rdy_2nd got %b exp 1", enq_rdy);
        end
        tick();
        enq_msg = 8'h33;
        checks++;
        if (enq_rdy !== 1'b0) begin
            errors++; $display("FAIL bp_rdy_3rd got %b exp 0", enq_rdy);
        end
        tick();
        checks++;
        if (deq_val !== 1'b1 || deq_msg !== 8'h11 || enq_rdy !== 1'b0) begin
            errors++; $display("FAIL bp_hold got val %b msg %h rdy %b exp 1 11 0", deq_val, deq_msg, enq_rdy);
        end
        deq_rdy = 1'b1;
        tick();
        checks++;
        if (deq_val !== 1'b1 || deq_msg !== 8'h22 || enq_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_second got val %b msg %h rdy %b exp 1 22 1", deq_val, deq_msg, enq_rdy);
        end
        tick();
        enq_val = 1'b0;
        checks++;
        if (deq_val !== 1'b1 || deq_msg !== 8'h33) begin
            errors++; $display("FAIL bp_third got val %b msg %h exp 1 33", deq_val, deq_msg);
        end
        tick();
        checks++;
        if (deq_val !== 1'b0) begin
            errors++; $display("FAIL bp_drain got %b exp 0", deq_val);
        end
    endtask

    task automatic test_random();
        int            sent;
        int            e0;
        int            d0;
        int            cyc;
        bit            was_stall;
        logic [NB-1:0] prev_msg;
        sent = 0; e0 = n_enq; d0 = n_deq; cyc = 0; was_stall = 0; prev_msg = '0;
        enq_msg = NB'($urandom);
        while (((n_enq - e0) < 200 || mq.size() > 0) && cyc < 5000) begin
            enq_val = ((n_enq - e0) < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            deq_rdy = 1'($urandom_range(0, 1));
            was_stall = deq_val && !deq_rdy;
            prev_msg  = deq_msg;
            sent = n_enq;
            tick();
            cyc++;
            // A new message is offered only once the previous one was taken.
            if (n_enq != sent) enq_msg = NB'($urandom);
            checks++;
            if (enq_rdy !== (mq.size() < 2) || deq_val !== (mq.size() > 0)) begin
                errors++; $display("FAIL rand_flags cyc %0d got rdy %b val %b exp occupancy %0d",
                                   cyc, enq_rdy, deq_val, mq.size());
            end
            if (mq.size() > 0) begin
                checks++;
                if (deq_msg !== mq[0]) begin
                    errors++; $display("FAIL rand_msg cyc %0d got %h exp %h", cyc, deq_msg, mq[0]);
                end
            end
            if (was_stall) begin
                checks++;
                if (deq_msg !== prev_msg) begin
                    errors++; $display("FAIL rand_stable cyc %0d got %h exp %h", cyc, deq_msg, prev_msg);
                end
            end
        end
        enq_val = 1'b0;
        checks++;
        if ((n_enq - e0) != 200 || (n_deq - d0) != 200) begin
            errors++; $display("FAIL rand_totals got enq %0d deq %0d exp 200 200", n_enq - e0, n_deq - d0);
        end
    endtask

    task automatic test_reset_in_two();
        deq_rdy = 1'b0;
        enq_val = 1'b1; enq_msg = 8'h44; tick();
        enq_msg = 8'h55; tick();
        checks++;
        if (enq_rdy !== 1'b0 || deq_val !== 1'b1 || deq_msg !== 8'h44) begin
            errors++; $display("FAIL two_full got rdy %b val %b msg %h exp 0 1 44", enq_rdy, deq_val, deq_msg);
        end
        reset = 1'b1; enq_val = 1'b1; enq_msg = 8'h66; deq_rdy = 1'b1;
        tick();
        reset = 1'b0; enq_val = 1'b0;
        checks++;
        if (deq_val !== 1'b0 || enq_rdy !== 1'b1) begin
            errors++; $display("FAIL two_reset got val %b rdy %b exp 0 1", deq_val, enq_rdy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (deq_val !== 1'b0) begin
                errors++; $display("FAIL two_no_ghost cyc %0d got val %b msg %h exp val 0", i, deq_val, deq_msg);
            end
        end
        enq_val = 1'b1; enq_msg = 8'h77;
        tick();
        enq_val = 1'b0;
        checks++;
        if (deq_val !== 1'b1 || deq_msg !== 8'h77) begin
            errors++; $display("FAIL two_after got val %b msg %h exp 1 77", deq_val, deq_msg);
        end
        tick();
    endtask

`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
    task automatic test_stall_count();
        reset = 1'b1; enq_val = 1'b0; deq_rdy = 1'b0; tick();
        reset = 1'b0;
        checks++;
        if (stall_count !== 32'd0) begin
            errors++; $display("FAIL stall_init got %0d exp 0", stall_count);
        end
        enq_val = 1'b1; enq_msg = 8'h01; tick();
        enq_msg = 8'h02; tick();
        enq_msg = 8'h03;
        tick(); tick(); tick();
        enq_val = 1'b0;
        checks++;
        if (stall_count !== 32'd3 || stall_count !== m_stall) begin
            errors++; $display("FAIL stall_three got %0d exp 3", stall_count);
        end
        reset = 1'b1; tick();
        reset = 1'b0;
        checks++;
        if (stall_count !== 32'd0) begin
            errors++; $display("FAIL stall_reset got %0d exp 0", stall_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; enq_val = 1'b0; deq_rdy = 1'b1; enq_msg = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_in_two();
`ifdef ELASTIC_PIPE_REG_STALL_CNT_EN
        test_stall_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
